// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
//
// Shares one QPI memory controller between a framebuffer DMA read port and a
// CPU read/write port. A port holds its request high for the whole burst and
// keeps ownership until it drops the request. The arbiter then waits for the
// controller to report idle before arbitrating again. Ties alternate between
// the two ports, and FB wins the first tie after reset.
//
// Ports
//   clk_2x, rst                 clock; synchronous active-high reset
//   fb_addr, fb_do_read         framebuffer burst read request
//   fb_rdata, fb_next_word,     framebuffer return path
//   fb_is_idle
//   cpu_addr, cpu_wdata,        CPU request port
//   cpu_do_read, cpu_do_write
//   cpu_rdata, cpu_next_word,   CPU return path
//   cpu_is_idle
//   mem_addr, mem_wdata,        request side towards the QPI controller
//   mem_do_read, mem_do_write
//   mem_rdata, mem_next_word,   response side from the QPI controller
//   mem_is_idle
//   stat_clr, fb_wait_max       worst-case FB grant latency statistic

module fb_mem_arbiter (
    input  logic        clk_2x,
    input  logic        rst,

    input  logic [23:0] fb_addr,
    input  logic        fb_do_read,
    output logic [31:0] fb_rdata,
    output logic        fb_next_word,
    output logic        fb_is_idle,

    input  logic [23:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_do_read,
    input  logic        cpu_do_write,
    output logic [31:0] cpu_rdata,
    output logic        cpu_next_word,
    output logic        cpu_is_idle,

    output logic [23:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_do_read,
    output logic        mem_do_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_next_word,
    input  logic        mem_is_idle,

    input  logic        stat_clr,
    output logic [15:0] fb_wait_max
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FB    = 2'd1;
    localparam logic [1:0] ST_CPU   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        last_grant_cpu;
    logic        fb_first;
    logic [15:0] fb_wait;
    logic [23:0] addr_hold;
    logic [31:0] wdata_hold;
    logic        fb_req;
    logic        cpu_req;

    assign fb_req  = fb_do_read;
    assign cpu_req = cpu_do_read | cpu_do_write;

    // A new grant is only issued once the controller is idle. FB takes a
    // contested slot unless it was the previous owner.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (mem_is_idle) begin
                    if (fb_req && (!cpu_req || last_grant_cpu))
                        state_next = ST_FB;
                    else if (cpu_req)
                        state_next = ST_CPU;
                end
            end
            ST_FB: begin
                if (!fb_req)
                    state_next = ST_DRAIN;
            end
            ST_CPU: begin
                if (!cpu_req)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (mem_is_idle)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // fb_first marks the first cycle spent in ST_FB. fb_wait still holds the
    // full wait count on that cycle and is cleared at its end.
    always_ff @(posedge clk_2x) begin
        if (rst) begin
            state          <= ST_IDLE;
            last_grant_cpu <= 1'b1;
            fb_first       <= 1'b0;
        end else begin
            state    <= state_next;
            fb_first <= (state != ST_FB) && (state_next == ST_FB);
            if (state == ST_IDLE && state_next == ST_FB)
                last_grant_cpu <= 1'b0;
            else if (state == ST_IDLE && state_next == ST_CPU)
                last_grant_cpu <= 1'b1;
        end
    end

    // Counts the cycles FB has been asking without owning the memory.
    always_ff @(posedge clk_2x) begin
        if (rst)
            fb_wait <= 16'd0;
        else if (!fb_req || state == ST_FB)
            fb_wait <= 16'd0;
        else if (fb_wait != 16'hFFFF)
            fb_wait <= fb_wait + 16'd1;
    end

    // A clear request overrides an update that lands in the same cycle.
    always_ff @(posedge clk_2x) begin
        if (rst)
            fb_wait_max <= 16'd0;
        else if (stat_clr)
            fb_wait_max <= 16'd0;
        else if (fb_first && (fb_wait > fb_wait_max))
            fb_wait_max <= fb_wait;
    end

    // Keeps the last forwarded address/data so the controller sees stable
    // values while nobody owns it.
    always_ff @(posedge clk_2x) begin
        if (rst) begin
            addr_hold  <= 24'd0;
            wdata_hold <= 32'd0;
        end else if (state == ST_FB) begin
            addr_hold  <= fb_addr;
            wdata_hold <= 32'd0;
        end else if (state == ST_CPU) begin
            addr_hold  <= cpu_addr;
            wdata_hold <= cpu_wdata;
        end
    end

    always_comb begin
        mem_addr      = addr_hold;
        mem_wdata     = wdata_hold;
        mem_do_read   = 1'b0;
        mem_do_write  = 1'b0;
        fb_next_word  = 1'b0;
        cpu_next_word = 1'b0;
        fb_is_idle    = 1'b1;
        cpu_is_idle   = 1'b1;
        case (state)
            ST_FB: begin
                mem_addr     = fb_addr;
                mem_wdata    = 32'd0;
                mem_do_read  = fb_do_read;
                fb_next_word = mem_next_word;
                fb_is_idle   = mem_is_idle;
            end
            ST_CPU: begin
                mem_addr      = cpu_addr;
                mem_wdata     = cpu_wdata;
                mem_do_read   = cpu_do_read;
                mem_do_write  = cpu_do_write;
                cpu_next_word = mem_next_word;
                cpu_is_idle   = mem_is_idle;
            end
            default: begin
            end
        endcase
    end

    assign fb_rdata  = mem_rdata;
    assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter
//
// Testbench for fb_mem_arbiter. It runs a table of hand-derived cycle
// vectors, hand-written multi-cycle scenarios and a randomized run. Every
// cycle is also compared against a behavioural model of who owns the memory.
//
// Inputs change 1 ns after the rising edge. Outputs are compared on the
// falling edge.

module tb_fb_mem_arbiter;

    logic        clk_2x;
    logic        rst;
    logic [23:0] fb_addr;
    logic        fb_do_read;
    logic [31:0] fb_rdata;
    logic        fb_next_word;
    logic        fb_is_idle;
    logic [23:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_do_read;
    logic        cpu_do_write;
    logic [31:0] cpu_rdata;
    logic        cpu_next_word;
    logic        cpu_is_idle;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_do_read;
    logic        mem_do_write;
    logic [31:0] mem_rdata;
    logic        mem_next_word;
    logic        mem_is_idle;
    logic        stat_clr;
    logic [15:0] fb_wait_max;

    int n_vectors;
    int n_miscompares;

    // Reference model. owner: 0 = nobody, 1 = FB, 2 = CPU.
    int          m_owner;
    bit          m_drain;
    bit          m_last_cpu;
    int          m_wait;
    int          m_max;
    bit          m_fb_first;
    bit          m_hold_valid;
    logic [23:0] m_hold_addr;
    logic [31:0] m_hold_wdata;

    typedef struct packed {
        bit rst;
        bit fb;
        bit crd;
        bit cwr;
        bit midle;
        bit mnw;
        bit e_rd;
        bit e_wr;
        bit e_fbnw;
        bit e_cpunw;
        bit e_fbidle;
        bit e_cpuidle;
    } vec_t;

    vec_t tbl [18];

    fb_mem_arbiter dut (
        .clk_2x        (clk_2x),
        .rst           (rst),
        .fb_addr       (fb_addr),
        .fb_do_read    (fb_do_read),
        .fb_rdata      (fb_rdata),
        .fb_next_word  (fb_next_word),
        .fb_is_idle    (fb_is_idle),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_do_read   (cpu_do_read),
        .cpu_do_write  (cpu_do_write),
        .cpu_rdata     (cpu_rdata),
        .cpu_next_word (cpu_next_word),
        .cpu_is_idle   (cpu_is_idle),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_do_read   (mem_do_read),
        .mem_do_write  (mem_do_write),
        .mem_rdata     (mem_rdata),
        .mem_next_word (mem_next_word),
        .mem_is_idle   (mem_is_idle),
        .stat_clr      (stat_clr),
        .fb_wait_max   (fb_wait_max)
    );

    initial clk_2x = 1'b0;
    always #5 clk_2x = ~clk_2x;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput();
        bit g_fb;
        bit g_cpu;
        g_fb  = (m_owner == 1);
        g_cpu = (m_owner == 2);
        check_val("mem_do_read", 32'(mem_do_read),
                  32'((g_fb && fb_do_read) || (g_cpu && cpu_do_read)));
        check_val("mem_do_write", 32'(mem_do_write), 32'(g_cpu && cpu_do_write));
        check_val("fb_next_word", 32'(fb_next_word), 32'(g_fb && mem_next_word));
        check_val("cpu_next_word", 32'(cpu_next_word), 32'(g_cpu && mem_next_word));
        check_val("fb_is_idle", 32'(fb_is_idle), 32'(g_fb ? mem_is_idle : 1'b1));
        check_val("cpu_is_idle", 32'(cpu_is_idle), 32'(g_cpu ? mem_is_idle : 1'b1));
        check_val("fb_rdata", fb_rdata, mem_rdata);
        check_val("cpu_rdata", cpu_rdata, mem_rdata);
        check_val("fb_wait_max", 32'(fb_wait_max), 32'(m_max));
        if (g_fb) begin
            check_val("mem_addr", 32'(mem_addr), 32'(fb_addr));
            check_val("mem_wdata", mem_wdata, 32'd0);
        end else if (g_cpu) begin
            check_val("mem_addr", 32'(mem_addr), 32'(cpu_addr));
            check_val("mem_wdata", mem_wdata, cpu_wdata);
        end else if (m_hold_valid) begin
            check_val("mem_addr_hold", 32'(mem_addr), 32'(m_hold_addr));
            check_val("mem_wdata_hold", mem_wdata, m_hold_wdata);
        end
    endtask

    // Advance the model across one rising edge, using the inputs of the cycle.
    task automatic model_step();
        bit fbq;
        bit cpq;
        int n_wait;
        int n_max;
        bit n_first;
        fbq = fb_do_read;
        cpq = cpu_do_read | cpu_do_write;
        if (rst) begin
            m_owner      = 0;
            m_drain      = 0;
            m_last_cpu   = 1;
            m_wait       = 0;
            m_max        = 0;
            m_fb_first   = 0;
            m_hold_valid = 0;
            return;
        end
        n_wait  = (!fbq || m_owner == 1) ? 0 : ((m_wait < 65535) ? m_wait + 1 : 65535);
        n_max   = stat_clr ? 0 : ((m_fb_first && m_wait > m_max) ? m_wait : m_max);
        n_first = 0;
        if (m_owner == 1) begin
            m_hold_addr  = fb_addr;
            m_hold_wdata = 32'd0;
            m_hold_valid = 1;
        end else if (m_owner == 2) begin
            m_hold_addr  = cpu_addr;
            m_hold_wdata = cpu_wdata;
            m_hold_valid = 1;
        end
        if (m_owner == 1) begin
            if (!fbq) begin
                m_owner = 0;
                m_drain = 1;
            end
        end else if (m_owner == 2) begin
            if (!cpq) begin
                m_owner = 0;
                m_drain = 1;
            end
        end else if (m_drain) begin
            if (mem_is_idle) m_drain = 0;
        end else if (mem_is_idle) begin
            if (fbq && (!cpq || m_last_cpu)) begin
                m_owner    = 1;
                m_last_cpu = 0;
                n_first    = 1;
            end else if (cpq) begin
                m_owner    = 2;
                m_last_cpu = 1;
            end
        end
        m_wait     = n_wait;
        m_max      = n_max;
        m_fb_first = n_first;
    endtask

    // Inputs are already driven. Let them settle, then compare on the
    // falling edge.
    task automatic applyStimulus();
        @(negedge clk_2x);
        checkOutput();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk_2x);
        #1;
    endtask

    task automatic step();
        applyStimulus();
        advance();
    endtask

    task automatic idle_inputs();
        rst           = 1'b0;
        fb_do_read    = 1'b0;
        cpu_do_read   = 1'b0;
        cpu_do_write  = 1'b0;
        mem_next_word = 1'b0;
        mem_is_idle   = 1'b1;
        stat_clr      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk_2x);
        model_step();
        @(posedge clk_2x);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        n_vectors     = 0;
        n_miscompares = 0;
        fb_addr       = 24'h0;
        cpu_addr      = 24'h0;
        cpu_wdata     = 32'h0;
        mem_rdata     = 32'h0;

        //           rst fb crd cwr midle mnw | rd wr fbnw cpunw fbidle cpuidle
        tbl[0]  = 12'b0_1_1_0_1_0_0_0_0_0_1_1;
        tbl[1]  = 12'b0_1_1_0_0_1_1_0_1_0_0_1;
        tbl[2]  = 12'b0_1_1_0_1_0_1_0_0_0_1_1;
        tbl[3]  = 12'b0_0_1_0_0_1_0_0_1_0_0_1;
        tbl[4]  = 12'b0_0_1_0_0_1_0_0_0_0_1_1;
        tbl[5]  = 12'b0_0_1_0_1_0_0_0_0_0_1_1;
        tbl[6]  = 12'b0_0_1_0_1_0_0_0_0_0_1_1;
        tbl[7]  = 12'b0_1_1_1_0_1_1_1_0_1_1_0;
        tbl[8]  = 12'b0_1_0_1_1_0_0_1_0_0_1_1;
        tbl[9]  = 12'b0_1_0_0_1_0_0_0_0_0_1_1;
        tbl[10] = 12'b0_1_0_0_1_0_0_0_0_0_1_1;
        tbl[11] = 12'b0_1_1_0_1_0_0_0_0_0_1_1;
        tbl[12] = 12'b0_1_1_0_1_1_1_0_1_0_1_1;
        tbl[13] = 12'b1_1_0_0_0_0_1_0_0_0_0_1;
        tbl[14] = 12'b0_0_0_0_1_0_0_0_0_0_1_1;
        tbl[15] = 12'b0_0_1_0_0_0_0_0_0_0_1_1;
        tbl[16] = 12'b0_0_0_0_1_0_0_0_0_0_1_1;
        tbl[17] = 12'b0_0_0_0_1_0_0_0_0_0_1_1;

        // Table: tie after reset goes to FB, then CPU, then FB again;
        // requests wait during drain; reset mid-burst; a withdrawn request
        // gets no grant.
        do_reset();
        check_val("reset_fb_is_idle", 32'(fb_is_idle), 32'd1);
        check_val("reset_cpu_is_idle", 32'(cpu_is_idle), 32'd1);
        check_val("reset_mem_do_read", 32'(mem_do_read), 32'd0);
        check_val("reset_fb_wait_max", 32'(fb_wait_max), 32'd0);
        for (int i = 0; i < 18; i++) begin
            rst           = tbl[i].rst;
            fb_do_read    = tbl[i].fb;
            cpu_do_read   = tbl[i].crd;
            cpu_do_write  = tbl[i].cwr;
            mem_is_idle   = tbl[i].midle;
            mem_next_word = tbl[i].mnw;
            fb_addr       = 24'($urandom);
            cpu_addr      = 24'($urandom);
            cpu_wdata     = $urandom;
            mem_rdata     = $urandom;
            applyStimulus();
            check_val($sformatf("tbl%0d_rd", i), 32'(mem_do_read), 32'(tbl[i].e_rd));
            check_val($sformatf("tbl%0d_wr", i), 32'(mem_do_write), 32'(tbl[i].e_wr));
            check_val($sformatf("tbl%0d_fbnw", i), 32'(fb_next_word), 32'(tbl[i].e_fbnw));
            check_val($sformatf("tbl%0d_cpunw", i), 32'(cpu_next_word), 32'(tbl[i].e_cpunw));
            check_val($sformatf("tbl%0d_fbidle", i), 32'(fb_is_idle), 32'(tbl[i].e_fbidle));
            check_val($sformatf("tbl%0d_cpuidle", i), 32'(cpu_is_idle), 32'(tbl[i].e_cpuidle));
            advance();
        end

        // FB-only burst: granted one cycle after the request, and all 32
        // words are routed to FB only.
        do_reset();
        fb_do_read = 1'b1;
        fb_addr    = 24'h001000;
        step();
        mem_is_idle = 1'b0;
        applyStimulus();
        check_val("fbonly_rd", 32'(mem_do_read), 32'd1);
        check_val("fbonly_addr", 32'(mem_addr), 32'h001000);
        advance();
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            mem_next_word = 1'b1;
            mem_rdata     = $urandom;
            applyStimulus();
            if (fb_next_word === 1'b1) pulses++;
            check_val("fbonly_cpunw", 32'(cpu_next_word), 32'd0);
            advance();
        end
        check_val("fbonly_pulses", 32'(pulses), 32'd32);
        fb_do_read    = 1'b0;
        mem_next_word = 1'b0;
        step();

        // FB waits behind a CPU write. The CPU drops at cycle 10, the
        // controller frees up in time for the arbiter to be idle at cycle 13,
        // and FB is granted at cycle 14 after 14 cycles of waiting.
        do_reset();
        cpu_do_write = 1'b1;
        cpu_addr     = 24'h00BEEF;
        cpu_wdata    = 32'hCAFE0001;
        step();
        for (int t = 0; t < 16; t++) begin
            fb_do_read   = 1'b1;
            fb_addr      = 24'h00ABC0;
            cpu_do_write = (t < 10);
            mem_is_idle  = (t >= 12);
            applyStimulus();
            if (t == 13) check_val("wait_idle_rd", 32'(mem_do_read), 32'd0);
            if (t == 14) check_val("wait_grant_rd", 32'(mem_do_read), 32'd1);
            if (t == 15) check_val("wait_max14", 32'(fb_wait_max), 32'd14);
            advance();
        end

        // Reset during a CPU burst: outputs drop at once and the statistic
        // is cleared.
        fb_do_read = 1'b0;
        step();
        step();
        cpu_do_read  = 1'b1;
        cpu_do_write = 1'b1;
        step();
        mem_is_idle = 1'b0;
        applyStimulus();
        check_val("rstburst_pre_wr", 32'(mem_do_write), 32'd1);
        advance();
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus();
        check_val("rstburst_rd", 32'(mem_do_read), 32'd0);
        check_val("rstburst_wr", 32'(mem_do_write), 32'd0);
        check_val("rstburst_fbidle", 32'(fb_is_idle), 32'd1);
        check_val("rstburst_cpuidle", 32'(cpu_is_idle), 32'd1);
        check_val("rstburst_max", 32'(fb_wait_max), 32'd0);
        advance();

        // A one-cycle CPU pulse during drain is gone before arbitration.
        do_reset();
        cpu_do_read = 1'b1;
        step();
        cpu_do_read = 1'b0;
        mem_is_idle = 1'b0;
        step();
        cpu_do_read = 1'b1;
        mem_is_idle = 1'b1;
        step();
        cpu_do_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            check_val("withdraw_rd", 32'(mem_do_read), 32'd0);
            check_val("withdraw_cpuidle", 32'(cpu_is_idle), 32'd1);
            advance();
        end

        // FB waits long enough to saturate the counter. A clear that
        // coincides with the next update wins over it.
        do_reset();
        cpu_do_read = 1'b1;
        step();
        fb_do_read  = 1'b1;
        mem_is_idle = 1'b0;
        for (int i = 0; i < 70000; i++) step();
        cpu_do_read = 1'b0;
        step();
        mem_is_idle = 1'b1;
        step();
        step();
        applyStimulus();
        check_val("sat_grant_rd", 32'(mem_do_read), 32'd1);
        advance();
        applyStimulus();
        check_val("sat_max", 32'(fb_wait_max), 32'hFFFF);
        advance();
        fb_do_read = 1'b0;
        step();
        step();
        cpu_do_read = 1'b1;
        step();
        fb_do_read  = 1'b1;
        mem_is_idle = 1'b0;
        for (int i = 0; i < 5; i++) step();
        cpu_do_read = 1'b0;
        step();
        mem_is_idle = 1'b1;
        step();
        step();
        stat_clr = 1'b1;
        applyStimulus();
        check_val("clr_grant_rd", 32'(mem_do_read), 32'd1);
        advance();
        stat_clr = 1'b0;
        applyStimulus();
        check_val("clr_max", 32'(fb_wait_max), 32'd0);
        advance();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) fb_do_read = ~fb_do_read;
            if ($urandom_range(0, 7) == 0) cpu_do_read = ~cpu_do_read;
            if ($urandom_range(0, 9) == 0) cpu_do_write = ~cpu_do_write;
            mem_is_idle   = ($urandom_range(0, 2) != 0);
            mem_next_word = 1'($urandom);
            stat_clr      = ($urandom_range(0, 63) == 0);
            rst           = ($urandom_range(0, 499) == 0);
            fb_addr       = 24'($urandom);
            cpu_addr      = 24'($urandom);
            cpu_wdata     = $urandom;
            mem_rdata     = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/fb_mem_arbiter.md
FB_MEM_ARBITER -- requirements
Module: fb_mem_arbiter

Interface
REQ-001 SHALL have clk_2x  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have fb_addr  in  24, fb_do_read  in  1: framebuffer DMA read-burst request (held high for the burst).
REQ-004 SHALL have fb_rdata  out  32, fb_next_word  out  1, fb_is_idle  out  1: framebuffer return path.
REQ-005 SHALL have cpu_addr  in  24, cpu_wdata  in  32, cpu_do_read  in  1, cpu_do_write  in  1: CPU request port.
REQ-006 SHALL have cpu_rdata  out  32, cpu_next_word  out  1, cpu_is_idle  out  1: CPU return path.
REQ-007 SHALL have mem_addr  out  24, mem_wdata  out  32, mem_do_read  out  1, mem_do_write  out  1: to QPI controller.
REQ-008 SHALL have mem_rdata  in  32, mem_next_word  in  1, mem_is_idle  in  1: from QPI controller.
REQ-009 SHALL have stat_clr  in  1 and fb_wait_max  out  16: worst-case FB grant latency in clk_2x cycles.

Function
REQ-010 SHALL implement states ST_IDLE, ST_FB, ST_CPU, ST_DRAIN in a registered state machine.
REQ-011 SHALL treat fb_do_read as FB request and (cpu_do_read | cpu_do_write) as CPU request.
REQ-012 ST_IDLE: only when mem_is_idle=1, go ST_FB if FB req and (no CPU req or last grant=CPU); else ST_CPU if CPU req; else stay.
REQ-013 SHALL record last grant (FB/CPU) on entry to ST_FB/ST_CPU; reset value CPU, so FB wins the first tie.
REQ-014 ST_FB: leave to ST_DRAIN on the first cycle fb_do_read=0; ST_CPU: leave to ST_DRAIN on the first cycle both cpu_do_read=0 and cpu_do_write=0.
REQ-015 ST_DRAIN: go ST_IDLE on the first cycle mem_is_idle=1; stay otherwise.
REQ-016 mem_addr/mem_wdata SHALL be muxed from the granted port (FB: wdata=0); in ST_IDLE/ST_DRAIN hold the last granted port's values.
REQ-017 mem_do_read = (ST_FB & fb_do_read) | (ST_CPU & cpu_do_read); mem_do_write = ST_CPU & cpu_do_write; combinational from state register.
REQ-018 Grant latency: a request seen in ST_IDLE with mem_is_idle=1 SHALL reach mem_do_* exactly one cycle later.
REQ-019 mem_next_word SHALL be routed combinationally to the granted port only; the other port's next_word SHALL be 0; in ST_IDLE/ST_DRAIN both SHALL be 0.
REQ-020 fb_rdata and cpu_rdata SHALL both equal mem_rdata unconditionally (qualified by next_word).
REQ-021 port_is_idle SHALL be 1 when that port is not in its grant state, and equal mem_is_idle when it is.
REQ-022 A request withdrawn before grant SHALL produce no grant and no memory activity.
REQ-023 Requests arriving in ST_DRAIN SHALL wait; arbitration re-evaluated in ST_IDLE.
REQ-024 Simultaneous cpu_do_read and cpu_do_write SHALL be forwarded unchanged; no protocol checking.
REQ-025 fb_wait counter (16 bit): cleared when fb_do_read=0 or in ST_FB; increments each cycle fb_do_read=1 outside ST_FB, saturating at 0xFFFF.
REQ-026 On entry to ST_FB, fb_wait_max SHALL update to max(fb_wait_max, fb_wait) the following cycle.
REQ-027 stat_clr=1 SHALL zero fb_wait_max next cycle, taking priority over a simultaneous update.

Reset
REQ-028 rst SHALL force ST_IDLE, last grant=CPU, fb_wait=0, fb_wait_max=0.
REQ-029 After reset edge: mem_do_read=0, mem_do_write=0, fb_next_word=0, cpu_next_word=0, fb_is_idle=1, cpu_is_idle=1.
REQ-030 rst mid-burst SHALL drop mem_do_* the next cycle with no completion to either port; memory recovery is the controller's duty.

Verification
REQ-031 FB only: fb_do_read=1 at cycle 0, fb_addr=0x001000, mem idle -> mem_do_read=1, mem_addr=0x001000 at cycle 1; 32 mem_next_word pulses all on fb_next_word, cpu_next_word=0.
REQ-032 Tie after reset: FB and CPU request same cycle -> FB granted; after FB drops and mem idle -> CPU granted; next tie -> FB again.
REQ-033 CPU write in progress, FB requests at cycle 0, CPU drops at cycle 10, mem_is_idle=1 at cycle 13 -> ST_FB at cycle 14, mem_do_read=1 at 14, fb_wait_max=14.
REQ-034 Withdrawal: cpu_do_read pulsed 1 cycle while in ST_DRAIN -> no CPU grant, mem_do_read stays 0.
REQ-035 Saturation/clear: FB waits 70000 cycles -> fb_wait_max=0xFFFF; stat_clr=1 together with next grant update -> fb_wait_max=0.
REQ-036 Reset during CPU burst -> next cycle mem_do_read=0, mem_do_write=0, both is_idle=1, fb_wait_max=0.
